alu_issue: RTL

- Producer side of the ALU operand interface: `a`, `b` and the 5-bit `alu_mode`.
- Accepts decoded RV32I instruction fields from the decode stage over a valid/ready handshake.
- Selects the operands, encodes `alu_mode`, and holds the results in a 2-entry skid buffer that feeds the ALU.
- Sits between decode and execute; gives full throughput under back-pressure with no combinational ready path.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mode_decode.sv | 73 +++++++
 rtl/alu_issue.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU mode codes, RV32I opcodes
// and the entry record carried through the skid buffer.
package alu_pkg;

    localparam int XLEN = 32;

    // ALU mode codes driven on alu_mode
    localparam logic [4:0] MODE_ADD  = 5'h00;
    localparam logic [4:0] MODE_LLS  = 5'h01;
    localparam logic [4:0] MODE_SSLT = 5'h02;
    localparam logic [4:0] MODE_USLT = 5'h03;
    localparam logic [4:0] MODE_XOR  = 5'h04;
    localparam logic [4:0] MODE_LRS  = 5'h05;
    localparam logic [4:0] MODE_OR   = 5'h06;
    localparam logic [4:0] MODE_AND  = 5'h07;
    localparam logic [4:0] MODE_SUB  = 5'h10;
    localparam logic [4:0] MODE_ARS  = 5'h15;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // One buffered ALU request
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      mode;
        logic            illegal;
    } entry_t;

endpackage

// File: rtl/alu_mode_decode.sv
// Combinational translation of decoded instruction fields into an ALU entry:
// operand selection plus mode encoding. Unsupported encodings produce a
// zeroed ADD entry flagged illegal so that it still flows downstream.
module alu_mode_decode
    import alu_pkg::*;
(
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7b5,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    output entry_t          o_entry
);

    // Operand select and mode encoding per opcode class
    always_comb begin
        o_entry = '0;
        case (i_opcode)
            OPC_OP: begin
                o_entry.a    = i_rs1_val;
                o_entry.b    = i_rs2_val;
                o_entry.mode = {i_funct7b5, 1'b0, i_funct3};
            end
            OPC_OP_IMM: begin
                o_entry.a = i_rs1_val;
                o_entry.b = i_imm;
                // Only the shift-right group uses bit 30; ADDI must never turn into SUB
                if (i_funct3 == 3'b101) begin
                    o_entry.mode = {i_funct7b5, 1'b0, i_funct3};
                end else begin
                    o_entry.mode = {2'b00, i_funct3};
                end
            end
            OPC_LUI: begin
                o_entry.b = i_imm;
            end
            OPC_AUIPC: begin
                o_entry.a = i_pc;
                o_entry.b = i_imm;
            end
            OPC_LOAD, OPC_STORE: begin
                o_entry.a = i_rs1_val;
                o_entry.b = i_imm;
            end
            OPC_JAL, OPC_JALR: begin
                o_entry.a = i_pc;
                o_entry.b = XLEN'(4);
            end
            OPC_BRANCH: begin
                o_entry.a = i_rs1_val;
                o_entry.b = i_rs2_val;
                case (i_funct3[2:1])
                    2'b00:   o_entry.mode = MODE_SUB;
                    2'b10:   o_entry.mode = MODE_SSLT;
                    2'b11:   o_entry.mode = MODE_USLT;
                    default: o_entry.illegal = 1'b1;
                endcase
            end
            default: begin
                o_entry.illegal = 1'b1;
            end
        endcase
        // Illegal entries carry no operand data
        if (o_entry.illegal) begin
            o_entry.a    = '0;
            o_entry.b    = '0;
            o_entry.mode = MODE_ADD;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes instruction fields into ALU operands/mode and
// holds them in a two-entry skid buffer. in_ready depends only on the
// registered occupancy, so there is no combinational path from out_ready.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WordSize = 32,
    parameter int Depth    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          in_opcode,
    input  logic [2:0]          in_funct3,
    input  logic                in_funct7b5,
    input  logic [WordSize-1:0] in_rs1_val,
    input  logic [WordSize-1:0] in_rs2_val,
    input  logic [WordSize-1:0] in_imm,
    input  logic [WordSize-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WordSize-1:0] alu_a,
    output logic [WordSize-1:0] alu_b,
    output logic [4:0]          alu_mode,
    output logic                out_illegal
);

    // Buffer is full at Depth entries; only Depth == 2 is supported
    localparam logic [1:0] FULL = 2'(Depth);

    entry_t     w_new;
    entry_t     r_head;
    entry_t     r_tail;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    alu_mode_decode u_decode (
        .i_opcode   (in_opcode),
        .i_funct3   (in_funct3),
        .i_funct7b5 (in_funct7b5),
        .i_rs1_val  (in_rs1_val),
        .i_rs2_val  (in_rs2_val),
        .i_imm      (in_imm),
        .i_pc       (in_pc),
        .o_entry    (w_new)
    );

    assign in_ready    = (r_count != FULL) & ~rst;
    assign out_valid   = (r_count != 2'd0);
    assign w_push      = in_valid & in_ready;
    assign w_pop       = out_valid & out_ready;

    assign alu_a       = r_head.a;
    assign alu_b       = r_head.b;
    assign alu_mode    = r_head.mode;
    assign out_illegal = r_head.illegal;

    // Occupancy tracking and entry storage; head always drives the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= w_new;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= w_new;
                    end else if (w_push) begin
                        r_tail  <= w_new;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a pop can occur
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule
